bratcr_ctrl: RTL and testbench

//  Checkpoint-slot controller for the FRAT Branch RAT Copy Registers (BRATCR).
//  - Allocates one slot per issuing branch/store, in order, and reports the slot index so the FRAT snapshots the RAT into it.
//  - Frees slots as branches retire from the ROB.
//  - On mispredict, locates the matching checkpoint, sequences a restore, truncates younger slots and stalls rename until done.

---
 rtl/bratcr_ctrl_pkg.sv | 26 ++
 rtl/bratcr_ctrl_robid_cam.sv | 23 ++
 rtl/bratcr_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_bratcr_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bratcr_ctrl_pkg.sv
// Shared constants, FSM state encoding and slot metadata for the BRATCR
// checkpoint-slot controller.
package bratcr_ctrl_pkg;

    localparam int unsigned BRATCR_NUM_ETY      = 4;
    localparam int unsigned BRATCR_NUM_ETY_CLOG = 2;
    localparam int unsigned ISSUE_WIDTH_MAX     = 2;
    localparam int unsigned ROB_MAX_RETIRE      = 2;
    localparam int unsigned ROB_SIZE_CLOG       = 5;
    localparam int unsigned RECOVERY_CYCLES     = 2;

    localparam int unsigned FREE_CNT_W  = BRATCR_NUM_ETY_CLOG + 1;
    localparam int unsigned DRAIN_CNT_W = $clog2(RECOVERY_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESTORE = 2'd1,
        DRAIN   = 2'd2
    } bratcr_state_e;

    typedef struct packed {
        logic                     vld;
        logic [ROB_SIZE_CLOG-1:0] robid;
    } bratcr_meta_t;

endpackage

// File: rtl/bratcr_ctrl_robid_cam.sv
// Valid-qualified ROB-id match across all checkpoint slots; lowest index wins.
module bratcr_robid_cam
    import bratcr_ctrl_pkg::*;
(
    input  bratcr_meta_t [BRATCR_NUM_ETY-1:0] slots,
    input  logic [ROB_SIZE_CLOG-1:0]          tag,
    output logic                              hit_c,
    output logic [BRATCR_NUM_ETY_CLOG-1:0]    hit_idx_c
);

    // Scan high to low so the lowest matching slot is the one reported
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int i = BRATCR_NUM_ETY - 1; i >= 0; i--) begin
            if (slots[i].vld && (slots[i].robid == tag)) begin
                hit_c     = 1'b1;
                hit_idx_c = BRATCR_NUM_ETY_CLOG'(i);
            end
        end
    end

endmodule

// File: rtl/bratcr_ctrl.sv
// BRATCR checkpoint-slot controller: in-order slot allocation, retire-driven
// freeing and mispredict restore sequencing.
// Optional macros: BRATCR_PERF_CNT_EN (saturating perf counters),
//                  BRATCR_ASSERT_EN (protocol assertions).
module bratcr_ctrl
    import bratcr_ctrl_pkg::*;
(
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [ISSUE_WIDTH_MAX-1:0]                    br_alloc_req,
    input  logic [ISSUE_WIDTH_MAX*ROB_SIZE_CLOG-1:0]      br_robid,
    output logic [ISSUE_WIDTH_MAX-1:0]                    alloc_gnt,
    output logic [ISSUE_WIDTH_MAX*BRATCR_NUM_ETY_CLOG-1:0] alloc_idx,
    output logic                                          rename_stall,
    input  logic [ROB_MAX_RETIRE-1:0]                     val_ret,
    input  logic [ROB_MAX_RETIRE-1:0]                     branch_ret,
    input  logic [ROB_MAX_RETIRE*ROB_SIZE_CLOG-1:0]       robid_ret,
    input  logic                                          branch_clear_id,
    input  logic [ROB_SIZE_CLOG-1:0]                      mispredict_tag_id,
    output logic                                          restore_val,
    output logic [BRATCR_NUM_ETY_CLOG-1:0]                restore_idx,
    output logic [BRATCR_NUM_ETY-1:0]                     ckpt_vld,
    output logic [FREE_CNT_W-1:0]                         free_cnt,
    output logic                                          recov_busy,
    output logic [31:0]                                   perf_alloc_stall_cnt,
    output logic [31:0]                                   perf_recov_cnt
);

    localparam int unsigned IDX_W = BRATCR_NUM_ETY_CLOG;

    bratcr_state_e                     state_q, state_d;
    logic [DRAIN_CNT_W-1:0]            drain_q, drain_d;
    bratcr_meta_t [BRATCR_NUM_ETY-1:0] slot_q, slot_d;
    logic [IDX_W-1:0]                  head_q, head_d, tail_q, tail_d;
    logic [IDX_W-1:0]                  rst_idx_q, rst_idx_d;
    logic [FREE_CNT_W-1:0]             free_q, free_d;

    logic                              cam_hit;
    logic [IDX_W-1:0]                  cam_idx;
    logic                              clear_hit;
    logic                              starved;
    logic [FREE_CNT_W-1:0]             req_n, ret_n, gnt_n;
    logic [IDX_W-1:0]                  req_ofs, hit_ofs, rel;
    logic [IDX_W-1:0]                  ret_ptr [ROB_MAX_RETIRE];

    bratcr_robid_cam u_cam (
        .slots     (slot_q),
        .tag       (mispredict_tag_id),
        .hit_c     (cam_hit),
        .hit_idx_c (cam_idx)
    );

    assign clear_hit = (state_q == IDLE) && branch_clear_id && cam_hit;

    // All-or-nothing in-order grant from the tail; freed-this-cycle slots not counted
    always_comb begin
        alloc_gnt = '0;
        alloc_idx = '0;
        starved   = 1'b0;
        req_n     = '0;
        req_ofs   = '0;
        for (int k = 0; k < ISSUE_WIDTH_MAX; k++) begin
            req_n = req_n + FREE_CNT_W'(br_alloc_req[k]);
        end
        for (int k = 0; k < ISSUE_WIDTH_MAX; k++) begin
            alloc_idx[k*IDX_W +: IDX_W] = tail_q + req_ofs;
            if (br_alloc_req[k]) begin
                req_ofs = req_ofs + 1'b1;
            end
        end
        if ((state_q == IDLE) && !branch_clear_id && (req_n != '0)) begin
            if (req_n <= free_q) begin
                alloc_gnt = br_alloc_req;
            end else begin
                starved = 1'b1;
            end
        end
    end

    assign rename_stall = starved || (state_q != IDLE) || branch_clear_id;
    assign recov_busy   = (state_q != IDLE);
    assign restore_val  = (state_q == RESTORE);
    assign restore_idx  = rst_idx_q;
    assign free_cnt     = free_q;

    // Per-slot valid view
    always_comb begin
        ckpt_vld = '0;
        for (int i = 0; i < BRATCR_NUM_ETY; i++) begin
            ckpt_vld[i] = slot_q[i].vld;
        end
    end

    // Slot/pointer update: retire first, then allocation, then mispredict truncation
    always_comb begin
        slot_d    = slot_q;
        head_d    = head_q;
        tail_d    = tail_q;
        free_d    = free_q;
        rst_idx_d = rst_idx_q;
        ret_n     = '0;
        gnt_n     = '0;
        hit_ofs   = '0;
        rel       = '0;
        for (int k = 0; k < ROB_MAX_RETIRE; k++) begin
            ret_ptr[k] = head_d;
            if (val_ret[k] && branch_ret[k]) begin
                slot_d[head_d].vld = 1'b0;
                head_d             = head_d + 1'b1;
                ret_n              = ret_n + 1'b1;
            end
        end
        for (int k = 0; k < ISSUE_WIDTH_MAX; k++) begin
            if (alloc_gnt[k]) begin
                slot_d[alloc_idx[k*IDX_W +: IDX_W]].vld   = 1'b1;
                slot_d[alloc_idx[k*IDX_W +: IDX_W]].robid = br_robid[k*ROB_SIZE_CLOG +: ROB_SIZE_CLOG];
                gnt_n = gnt_n + 1'b1;
            end
        end
        tail_d = tail_q + IDX_W'(gnt_n);
        free_d = free_q + ret_n - gnt_n;
        if (clear_hit) begin
            // Keep only slots strictly older than the hit, measured from the new head
            hit_ofs = cam_idx - head_d;
            for (int i = 0; i < BRATCR_NUM_ETY; i++) begin
                rel = IDX_W'(i) - head_d;
                if (rel >= hit_ofs) begin
                    slot_d[i].vld = 1'b0;
                end
            end
            tail_d    = cam_idx;
            free_d    = FREE_CNT_W'(BRATCR_NUM_ETY) - FREE_CNT_W'(hit_ofs);
            rst_idx_d = cam_idx;
        end
    end

    // Recovery FSM next state
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (clear_hit) begin
                    state_d = RESTORE;
                end
            end
            RESTORE: begin
                state_d = DRAIN;
                drain_d = DRAIN_CNT_W'(RECOVERY_CYCLES - 1);
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer and slot registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            drain_q   <= '0;
            slot_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            rst_idx_q <= '0;
            free_q    <= FREE_CNT_W'(BRATCR_NUM_ETY);
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            slot_q    <= slot_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            rst_idx_q <= rst_idx_d;
            free_q    <= free_d;
        end
    end

`ifdef BRATCR_PERF_CNT_EN
    logic [31:0] stall_cnt_q, recov_cnt_q;

    // Saturating counters for alloc-starved cycles and restore entries
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            recov_cnt_q <= '0;
        end else begin
            if (starved && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (clear_hit && (recov_cnt_q != '1)) begin
                recov_cnt_q <= recov_cnt_q + 32'd1;
            end
        end
    end

    assign perf_alloc_stall_cnt = stall_cnt_q;
    assign perf_recov_cnt       = recov_cnt_q;
`else
    assign perf_alloc_stall_cnt = '0;
    assign perf_recov_cnt       = '0;
`endif

`ifdef BRATCR_ASSERT_EN
    // Protocol checks: retire order, mispredict tag presence, idle-only mispredict
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < ROB_MAX_RETIRE; k++) begin
                if (val_ret[k] && branch_ret[k]) begin
                    assert (slot_q[ret_ptr[k]].vld &&
                            (slot_q[ret_ptr[k]].robid == robid_ret[k*ROB_SIZE_CLOG +: ROB_SIZE_CLOG]))
                    else $error("retire does not match head checkpoint");
                end
            end
            if (branch_clear_id) begin
                assert (state_q == IDLE) else $error("mispredict while recovering");
                if (state_q == IDLE) begin
                    assert (cam_hit) else $error("mispredict tag not found");
                end
            end
        end
    end
`else
    logic ret_chk_unused;
    assign ret_chk_unused = ^robid_ret ^ ^ret_ptr[0];
`endif

endmodule

// File: tb/tb_bratcr_ctrl.sv
// Directed self-checking bench for bratcr_ctrl.
module tb_bratcr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  br_alloc_req;
    logic [9:0]  br_robid;
    logic [1:0]  alloc_gnt;
    logic [3:0]  alloc_idx;
    logic        rename_stall;
    logic [1:0]  val_ret;
    logic [1:0]  branch_ret;
    logic [9:0]  robid_ret;
    logic        branch_clear_id;
    logic [4:0]  mispredict_tag_id;
    logic        restore_val;
    logic [1:0]  restore_idx;
    logic [3:0]  ckpt_vld;
    logic [2:0]  free_cnt;
    logic        recov_busy;
    logic [31:0] perf_alloc_stall_cnt;
    logic [31:0] perf_recov_cnt;

    int checks = 0;
    int errors = 0;

    bratcr_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .br_alloc_req         (br_alloc_req),
        .br_robid             (br_robid),
        .alloc_gnt            (alloc_gnt),
        .alloc_idx            (alloc_idx),
        .rename_stall         (rename_stall),
        .val_ret              (val_ret),
        .branch_ret           (branch_ret),
        .robid_ret            (robid_ret),
        .branch_clear_id      (branch_clear_id),
        .mispredict_tag_id    (mispredict_tag_id),
        .restore_val          (restore_val),
        .restore_idx          (restore_idx),
        .ckpt_vld             (ckpt_vld),
        .free_cnt             (free_cnt),
        .recov_busy           (recov_busy),
        .perf_alloc_stall_cnt (perf_alloc_stall_cnt),
        .perf_recov_cnt       (perf_recov_cnt)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        br_alloc_req      = '0;
        br_robid          = '0;
        val_ret           = '0;
        branch_ret        = '0;
        robid_ret         = '0;
        branch_clear_id   = 1'b0;
        mispredict_tag_id = '0;
    endtask

    // Advance one clock; sample point is 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Allocate robids a (issue slot 0) and b (issue slot 1)
    task automatic alloc_two(input logic [4:0] a, input logic [4:0] b);
        br_alloc_req = 2'b11;
        br_robid     = {b, a};
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (ckpt_vld !== 4'b0000) begin errors++; $display("FAIL reset_vld got=%b exp=0000", ckpt_vld); end
        checks++; if (free_cnt !== 3'd4) begin errors++; $display("FAIL reset_free got=%0d exp=4", free_cnt); end
        checks++; if ({restore_val, rename_stall, recov_busy} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got=%b exp=000", {restore_val, rename_stall, recov_busy}); end
        checks++; if (alloc_gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", alloc_gnt); end
        checks++; if ({perf_alloc_stall_cnt, perf_recov_cnt} !== 64'd0) begin errors++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_alloc_stall_cnt, perf_recov_cnt); end
    endtask

    task automatic test_alloc_pair();
        do_reset();
        br_alloc_req = 2'b11;
        br_robid     = {5'd4, 5'd3};
        #1;
        checks++; if (alloc_gnt !== 2'b11) begin errors++; $display("FAIL pair_gnt got=%b exp=11", alloc_gnt); end
        checks++; if (alloc_idx !== 4'b0100) begin errors++; $display("FAIL pair_idx got=%b exp=0100", alloc_idx); end
        checks++; if (rename_stall !== 1'b0) begin errors++; $display("FAIL pair_stall got=%b exp=0", rename_stall); end
        tick();
        clear_inputs();
        checks++; if (ckpt_vld !== 4'b0011) begin errors++; $display("FAIL pair_vld got=%b exp=0011", ckpt_vld); end
        checks++; if (free_cnt !== 3'd2) begin errors++; $display("FAIL pair_free got=%0d exp=2", free_cnt); end
    endtask

    task automatic test_full_wrap();
        logic [1:0] idx0;
        do_reset();
        alloc_two(5'd1, 5'd2);
        alloc_two(5'd3, 5'd4);
        checks++; if (free_cnt !== 3'd0) begin errors++; $display("FAIL full_free got=%0d exp=0", free_cnt); end
        br_alloc_req = 2'b01;
        br_robid     = {5'd0, 5'd5};
        val_ret      = 2'b01;
        branch_ret   = 2'b01;
        robid_ret    = {5'd0, 5'd1};
        #1;
        checks++; if (alloc_gnt !== 2'b00) begin errors++; $display("FAIL full_gnt got=%b exp=00", alloc_gnt); end
        checks++; if (rename_stall !== 1'b1) begin errors++; $display("FAIL full_stall got=%b exp=1", rename_stall); end
        tick();
        val_ret    = '0;
        branch_ret = '0;
        robid_ret  = '0;
        #1;
        idx0 = alloc_idx[1:0];
        checks++; if (ckpt_vld !== 4'b1110) begin errors++; $display("FAIL wrap_vld got=%b exp=1110", ckpt_vld); end
        checks++; if (alloc_gnt !== 2'b01) begin errors++; $display("FAIL wrap_gnt got=%b exp=01", alloc_gnt); end
        checks++; if (idx0 !== 2'd0) begin errors++; $display("FAIL wrap_idx got=%0d exp=0", idx0); end
        tick();
        clear_inputs();
        checks++; if ({ckpt_vld, free_cnt} !== {4'b1111, 3'd0}) begin errors++; $display("FAIL wrap_after got=%b/%0d exp=1111/0", ckpt_vld, free_cnt); end
    endtask

    task automatic test_mispredict();
        logic [1:0] idx0;
        do_reset();
        alloc_two(5'd5, 5'd6);
        br_alloc_req = 2'b01;
        br_robid     = {5'd0, 5'd7};
        tick();
        // cycle T: mispredict on robid 6 with a competing alloc request
        branch_clear_id   = 1'b1;
        mispredict_tag_id = 5'd6;
        br_robid          = {5'd0, 5'd8};
        #1;
        checks++; if ({alloc_gnt, rename_stall} !== 3'b001) begin errors++; $display("FAIL mp_T got=%b exp=001", {alloc_gnt, rename_stall}); end
        tick();
        clear_inputs();
        checks++; if ({restore_val, restore_idx} !== 3'b101) begin errors++; $display("FAIL mp_restore got=%b exp=101", {restore_val, restore_idx}); end
        checks++; if ({ckpt_vld, free_cnt} !== {4'b0001, 3'd3}) begin errors++; $display("FAIL mp_trunc got=%b/%0d exp=0001/3", ckpt_vld, free_cnt); end
        checks++; if ({rename_stall, recov_busy} !== 2'b11) begin errors++; $display("FAIL mp_T1_busy got=%b exp=11", {rename_stall, recov_busy}); end
        tick();
        checks++; if ({restore_val, rename_stall, recov_busy} !== 3'b011) begin errors++; $display("FAIL mp_T2 got=%b exp=011", {restore_val, rename_stall, recov_busy}); end
        tick();
        checks++; if ({rename_stall, recov_busy} !== 2'b11) begin errors++; $display("FAIL mp_T3 got=%b exp=11", {rename_stall, recov_busy}); end
        tick();
        br_alloc_req = 2'b01;
        br_robid     = {5'd0, 5'd8};
        #1;
        idx0 = alloc_idx[1:0];
        checks++; if ({rename_stall, recov_busy} !== 2'b00) begin errors++; $display("FAIL mp_T4 got=%b exp=00", {rename_stall, recov_busy}); end
        checks++; if ({alloc_gnt, idx0} !== 4'b0101) begin errors++; $display("FAIL mp_realloc got=%b exp=0101", {alloc_gnt, idx0}); end
        tick();
        clear_inputs();
    endtask

    task automatic test_mispredict_retire();
        logic [1:0] idx0;
        do_reset();
        alloc_two(5'd5, 5'd6);
        br_alloc_req = 2'b01;
        br_robid     = {5'd0, 5'd7};
        tick();
        clear_inputs();
        branch_clear_id   = 1'b1;
        mispredict_tag_id = 5'd6;
        val_ret           = 2'b01;
        branch_ret        = 2'b01;
        robid_ret         = {5'd0, 5'd5};
        tick();
        clear_inputs();
        checks++; if ({ckpt_vld, free_cnt} !== {4'b0000, 3'd4}) begin errors++; $display("FAIL mpr_state got=%b/%0d exp=0000/4", ckpt_vld, free_cnt); end
        checks++; if ({restore_val, restore_idx} !== 3'b101) begin errors++; $display("FAIL mpr_restore got=%b exp=101", {restore_val, restore_idx}); end
        tick();
        tick();
        tick();
        br_alloc_req = 2'b01;
        br_robid     = {5'd0, 5'd9};
        #1;
        idx0 = alloc_idx[1:0];
        checks++; if ({alloc_gnt, idx0} !== 4'b0101) begin errors++; $display("FAIL mpr_tail got=%b exp=0101", {alloc_gnt, idx0}); end
        tick();
        clear_inputs();
    endtask

    task automatic test_miss();
        do_reset();
        alloc_two(5'd5, 5'd6);
        branch_clear_id   = 1'b1;
        mispredict_tag_id = 5'd9;
        #1;
        checks++; if (rename_stall !== 1'b1) begin errors++; $display("FAIL miss_T_stall got=%b exp=1", rename_stall); end
        tick();
        clear_inputs();
        #1;
        checks++; if ({ckpt_vld, free_cnt} !== {4'b0011, 3'd2}) begin errors++; $display("FAIL miss_state got=%b/%0d exp=0011/2", ckpt_vld, free_cnt); end
        checks++; if ({restore_val, rename_stall, recov_busy} !== 3'b000) begin errors++; $display("FAIL miss_ctrl got=%b exp=000", {restore_val, rename_stall, recov_busy}); end
    endtask

    task automatic test_perf();
        logic [31:0] exp_stall, exp_recov;
`ifdef BRATCR_PERF_CNT_EN
        exp_stall = 32'd3;
        exp_recov = 32'd1;
`else
        exp_stall = 32'd0;
        exp_recov = 32'd0;
`endif
        do_reset();
        alloc_two(5'd1, 5'd2);
        alloc_two(5'd3, 5'd4);
        br_alloc_req = 2'b01;
        br_robid     = {5'd0, 5'd10};
        for (int c = 0; c < 3; c++) begin
            tick();
        end
        clear_inputs();
        branch_clear_id   = 1'b1;
        mispredict_tag_id = 5'd2;
        tick();
        clear_inputs();
        for (int c = 0; c < 4; c++) begin
            tick();
        end
        checks++; if (perf_alloc_stall_cnt !== exp_stall) begin errors++; $display("FAIL perf_stall got=%0d exp=%0d", perf_alloc_stall_cnt, exp_stall); end
        checks++; if (perf_recov_cnt !== exp_recov) begin errors++; $display("FAIL perf_recov got=%0d exp=%0d", perf_recov_cnt, exp_recov); end
        checks++; if ({ckpt_vld, recov_busy} !== {4'b0001, 1'b0}) begin errors++; $display("FAIL perf_state got=%b/%b exp=0001/0", ckpt_vld, recov_busy); end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_alloc_pair();
        test_full_wrap();
        test_mispredict();
        test_mispredict_retire();
        test_miss();
        test_perf();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
